// File: rtl/oled_pkg.sv
// Shared OLED geometry, RGB565 colour constants and band colour lookup for the level meter.
package oled_pkg;

    localparam int unsigned OLED_W      = 96;
    localparam int unsigned OLED_H      = 64;
    localparam int unsigned OLED_PIXELS = OLED_W * OLED_H;
    localparam int unsigned IDX_W       = 13;
    localparam int unsigned COORD_W     = 7;
    localparam int unsigned RGB_W       = 16;

    typedef logic [RGB_W-1:0] rgb565_t;

    localparam rgb565_t COL_BLACK  = 16'h0000;
    localparam rgb565_t COL_GREEN  = 16'h07E0;
    localparam rgb565_t COL_YELLOW = 16'hFFE0;
    localparam rgb565_t COL_RED    = 16'hF800;
    localparam rgb565_t COL_WHITE  = 16'hFFFF;

    // Innermost band is red, the one just outside it yellow, everything else green.
    function automatic rgb565_t band_colour(input int unsigned k, input int unsigned num_levels);
        if (k == num_levels)
            return COL_RED;
        else if (k + 1 == num_levels)
            return COL_YELLOW;
        else
            return COL_GREEN;
    endfunction

endpackage

// File: rtl/level_peak_tracker.sv
// Per-frame level latch with clamp, plus a peak-hold register that decays one step every DECAY_FRAMES frames.
module level_peak_tracker
    import oled_pkg::*;
#(
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned LEVEL_W      = 3,
    parameter int unsigned DECAY_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   pixel_index,
    input  logic [LEVEL_W-1:0] level_in,
    output logic [LEVEL_W-1:0] fill,
    output logic [LEVEL_W-1:0] peak_level
);

    localparam int unsigned CNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    logic [IDX_W-1:0]   prev_idx;
    logic [CNT_W-1:0]   decay_cnt;
    logic               frame_start_c;
    logic [LEVEL_W-1:0] new_fill_c;

    // A dwelling index of 0 only counts once: the previous index must have been non-zero.
    assign frame_start_c = (pixel_index == '0) && (prev_idx != '0);
    assign new_fill_c    = (32'(level_in) > NUM_LEVELS) ? LEVEL_W'(NUM_LEVELS) : level_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_idx   <= '1;
            fill       <= '0;
            peak_level <= '0;
            decay_cnt  <= '0;
        end else begin
            prev_idx <= pixel_index;
            if (frame_start_c) begin
                fill <= new_fill_c;
                if (new_fill_c >= peak_level) begin
                    peak_level <= new_fill_c;
                    decay_cnt  <= '0;
                end else if (32'(decay_cnt) == DECAY_FRAMES - 1) begin
                    peak_level <= peak_level - LEVEL_W'(1);
                    decay_cnt  <= '0;
                end else begin
                    decay_cnt <= decay_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/oled_level_meter.sv
// RGB565 nested-band level meter for the 96x64 OLED; one-cycle registered pixel output.
// Optional OLED_PEAK_MARKER_EN draws a white outline row pair on the held peak band.
module oled_level_meter
    import oled_pkg::*;
#(
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned LEVEL_W      = 3,
    parameter int unsigned X_LO         = 18,
    parameter int unsigned X_HI         = 77,
    parameter int unsigned Y_TOP        = 13,
    parameter int unsigned Y_BOT        = 49,
    parameter int unsigned Y_STEP       = 7,
    parameter int unsigned DECAY_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   pixel_index,
    input  logic [LEVEL_W-1:0] level_in,
    output logic [RGB_W-1:0]   oled_data,
    output logic [LEVEL_W-1:0] peak_level
);

    // Innermost band must still have top <= bottom.
    if (Y_TOP + 2 * (NUM_LEVELS - 1) * Y_STEP > Y_BOT) begin : g_geom_check
        $error("oled_level_meter: innermost band collapses, reduce NUM_LEVELS or Y_STEP");
    end

    logic [LEVEL_W-1:0] fill;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    rgb565_t            pixel_c;

    level_peak_tracker #(
        .NUM_LEVELS   (NUM_LEVELS),
        .LEVEL_W      (LEVEL_W),
        .DECAY_FRAMES (DECAY_FRAMES)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .pixel_index (pixel_index),
        .level_in    (level_in),
        .fill        (fill),
        .peak_level  (peak_level)
    );

    assign x_c = COORD_W'(pixel_index % IDX_W'(OLED_W));
    assign y_c = COORD_W'(pixel_index / IDX_W'(OLED_W));

    // Later (inner) bands overwrite earlier ones, so the innermost lit band wins.
    always_comb begin
        pixel_c = COL_BLACK;
        if ((32'(pixel_index) < OLED_PIXELS) && (32'(x_c) >= X_LO) && (32'(x_c) <= X_HI)) begin
            for (int unsigned k = 1; k <= NUM_LEVELS; k++) begin
                if ((k <= 32'(fill)) &&
                    (32'(y_c) >= Y_TOP + (k - 1) * Y_STEP) &&
                    (32'(y_c) <= Y_BOT - (k - 1) * Y_STEP))
                    pixel_c = band_colour(k, NUM_LEVELS);
            end
`ifdef OLED_PEAK_MARKER_EN
            if (peak_level > fill) begin
                for (int unsigned k = 1; k <= NUM_LEVELS; k++) begin
                    if ((k == 32'(peak_level)) &&
                        ((32'(y_c) == Y_TOP + (k - 1) * Y_STEP) ||
                         (32'(y_c) == Y_BOT - (k - 1) * Y_STEP)))
                        pixel_c = COL_WHITE;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            oled_data <= '0;
        else
            oled_data <= pixel_c;
    end

endmodule

// File: tb/tb_oled_level_meter.sv
// Self-checking bench for oled_level_meter: vector table, directed corner sequences and randomized run vs a model.
module tb_oled_level_meter;

    localparam int N      = 3;
    localparam int LW     = 3;
    localparam int X_LO   = 18;
    localparam int X_HI   = 77;
    localparam int Y_TOP  = 13;
    localparam int Y_BOT  = 49;
    localparam int Y_STEP = 7;
    localparam int DECAY  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [12:0]   pixel_index;
    logic [LW-1:0] level_in;
    logic [15:0]   oled_data;
    logic [LW-1:0] peak_level;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, defined by frame-level rules.
    int fill_m, peak_m, frames_since_m, prev_m;

    always #5 clk = ~clk;

    oled_level_meter #(
        .NUM_LEVELS (N), .LEVEL_W (LW), .X_LO (X_LO), .X_HI (X_HI),
        .Y_TOP (Y_TOP), .Y_BOT (Y_BOT), .Y_STEP (Y_STEP), .DECAY_FRAMES (DECAY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_index (pixel_index),
        .level_in    (level_in),
        .oled_data   (oled_data),
        .peak_level  (peak_level)
    );

    typedef struct {
        int          lvl;
        int          x;
        int          y;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Band depth from distance to the nearest outer edge of band 1.
    function automatic logic [15:0] model_pix(input int idx, input int f, input int p);
        int x, y, d, band;
        logic [15:0] c;
        if (idx >= 6144) return 16'h0000;
        x = idx % 96;
        y = idx / 96;
        if (x < X_LO || x > X_HI) return 16'h0000;
        d = (y - Y_TOP < Y_BOT - y) ? (y - Y_TOP) : (Y_BOT - y);
        c = 16'h0000;
        if (d >= 0 && f > 0) begin
            band = d / Y_STEP + 1;
            if (band > N) band = N;
            if (band > f) band = f;
            if (band == N)          c = 16'hF800;
            else if (band == N - 1) c = 16'hFFE0;
            else                    c = 16'h07E0;
        end
`ifdef OLED_PEAK_MARKER_EN
        if (p > f && d >= 0 && d == (p - 1) * Y_STEP) c = 16'hFFFF;
`else
        if (p < 0) c = 16'h0000;
`endif
        return c;
    endfunction

    task automatic model_reset();
        fill_m = 0; peak_m = 0; frames_since_m = 0; prev_m = 8191;
    endtask

    task automatic model_step(input int idx, input int lvl);
        int nf;
        if (idx == 0 && prev_m != 0) begin
            nf = (lvl > N) ? N : lvl;
            if (nf >= peak_m) begin
                peak_m = nf; frames_since_m = 0;
            end else begin
                frames_since_m++;
                if (frames_since_m == DECAY) begin
                    peak_m--; frames_since_m = 0;
                end
            end
            fill_m = nf;
        end
        prev_m = idx;
    endtask

    // One clock: drive, clock, then check registered pixel and peak against the model.
    task automatic cyc(input int idx, input int lvl);
        logic [15:0] exp;
        pixel_index = 13'(idx);
        level_in    = LW'(lvl);
        exp = model_pix(idx, fill_m, peak_m);
        @(posedge clk);
        #1;
        model_step(idx, lvl);
        check("pixel", 32'(oled_data), 32'(exp));
        check("peak", 32'(peak_level), 32'(peak_m));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            pixel_index = 13'($urandom_range(0, 8191));
            level_in    = LW'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            check("reset_data", 32'(oled_data), 32'h0);
            check("reset_peak", 32'(peak_level), 32'h0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic frame(input int lvl);
        cyc(1, lvl);
        cyc(0, lvl);
    endtask

    task automatic probe(input int x, input int y, input int lvl);
        cyc(y * 96 + x, lvl);
    endtask

    int peaks_exp[7];
    int r, idx, lvl;

    initial begin
        reset = 1'b1;
        pixel_index = '0;
        level_in = '0;
        model_reset();

        do_reset(3);

        // Black until the first frame start after reset
        probe(40, 30, 3);
        check("post_reset_black", 32'(oled_data), 32'h0);

        vecs.push_back('{2, 20, 15, 16'h07E0});
        vecs.push_back('{2, 20, 22, 16'hFFE0});
        vecs.push_back('{2, 20, 30, 16'hFFE0});
        vecs.push_back('{2, 17, 30, 16'h0000});
        vecs.push_back('{2, 78, 30, 16'h0000});
        vecs.push_back('{2, 18, 13, 16'h07E0});
        vecs.push_back('{2, 77, 49, 16'h07E0});
        vecs.push_back('{2, 20, 12, 16'h0000});
        vecs.push_back('{2, 20, 50, 16'h0000});
        vecs.push_back('{3, 40, 30, 16'hF800});
        vecs.push_back('{3, 40, 27, 16'hF800});
        vecs.push_back('{3, 40, 26, 16'hFFE0});
        vecs.push_back('{3, 40, 35, 16'hF800});
        vecs.push_back('{3, 40, 36, 16'hFFE0});
        vecs.push_back('{7, 40, 30, 16'hF800});
        vecs.push_back('{7, 40, 27, 16'hF800});
        vecs.push_back('{7, 40, 26, 16'hFFE0});
        vecs.push_back('{1, 40, 30, 16'h07E0});
        vecs.push_back('{0, 40, 30, 16'h0000});
        foreach (vecs[i]) begin
            frame(vecs[i].lvl);
            probe(vecs[i].x, vecs[i].y, vecs[i].lvl);
            check($sformatf("vec%0d(%0d,%0d)", i, vecs[i].x, vecs[i].y), 32'(oled_data), 32'(vecs[i].exp));
        end

        // Out-of-range indices are black and do not start a frame
        do_reset(1);
        frame(3);
        cyc(6144, 1);
        check("oob_6144", 32'(oled_data), 32'h0);
        cyc(8191, 1);
        check("oob_8191", 32'(oled_data), 32'h0);
        probe(40, 30, 1);
        check("oob_no_fs", 32'(oled_data), 32'hF800);

        // Mid-frame level change is held off until the next frame start
        do_reset(1);
        frame(1);
        for (int i = 2995; i <= 3005; i++) cyc(i, (i >= 3000) ? 3 : 1);
        cyc(3010, 3);
        check("midframe_hold", 32'(oled_data), 32'h07E0);
        frame(3);
        cyc(3010, 3);
        check("midframe_next", 32'(oled_data), 32'hF800);

        // Dwell on index 0 yields a single frame start
        frame(2);
        cyc(0, 3);
        cyc(0, 3);
        probe(40, 30, 3);
        check("dwell_once", 32'(oled_data), 32'hFFE0);

        // Peak decay with DECAY_FRAMES=2
        do_reset(1);
        peaks_exp = '{3, 3, 2, 2, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            frame((i == 0) ? 3 : 0);
            check($sformatf("decay_peak%0d", i), 32'(peak_level), 32'(peaks_exp[i]));
            if (i > 0) begin
                probe(40, 30, 0);
                check($sformatf("decay_fill%0d", i), 32'(oled_data), 32'h0);
            end
        end

        // Peak marker rows on band 3 while fill is 1
        do_reset(1);
        frame(3);
        frame(1);
        check("marker_peak", 32'(peak_level), 32'd3);
        probe(40, 27, 1);
`ifdef OLED_PEAK_MARKER_EN
        check("marker_top", 32'(oled_data), 32'hFFFF);
`else
        check("marker_top", 32'(oled_data), 32'h07E0);
`endif
        probe(40, 35, 1);
`ifdef OLED_PEAK_MARKER_EN
        check("marker_bot", 32'(oled_data), 32'hFFFF);
`else
        check("marker_bot", 32'(oled_data), 32'h07E0);
`endif
        probe(40, 30, 1);
        check("marker_mid", 32'(oled_data), 32'h07E0);
        probe(10, 27, 1);
        check("marker_outside", 32'(oled_data), 32'h0);

        // Randomized: jumps, dwells, frame starts and occasional resets
        idx = 0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 2)       idx = 0;
            else if (r < 4)  idx = idx;
            else if (r < 5)  idx = int'($urandom_range(6144, 8191));
            else             idx = int'($urandom_range(1, 6143));
            lvl = int'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else cyc(idx, lvl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
